// File: rtl/reg_file32.sv
`default_nettype none
// ============================================================================
// Module      : reg_file32
// Description : General-purpose register file for the single-cycle datapath.
//               Depth is 2**ADDR_W registers of WIDTH bits each. Two purely
//               combinational read ports feed the ALU operands. One write port
//               commits write-back data on the rising clock edge. Register 0
//               is hard-wired to zero.
//
//               Ports:
//                 clk         rising-edge clock
//                 rst_n       asynchronous active-low reset, clears every register
//                 read_reg1   read port 1 address (rs)
//                 read_reg2   read port 2 address (rt)
//                 write_reg   write destination address
//                 write_data  write-back data
//                 reg_write   write enable, sampled on rising clk
//                 read_data1  contents of read_reg1 (ALU input1)
//                 read_data2  contents of read_reg2 (ALU input2)
//
//               BYPASS=1 forwards write_data to a read port that addresses the
//               register being written in the same cycle. BYPASS=0 returns the
//               stored value, so new data appears only after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file32 #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [WIDTH-1:0]  write_data,
    input  logic              reg_write,
    output logic [WIDTH-1:0]  read_data1,
    output logic [WIDTH-1:0]  read_data2
);

    localparam int C_DEPTH = 2 ** ADDR_W;
    localparam int C_NPORT = 2;

    // Flattened view of every register; entry 0 is a constant zero.
    logic [C_DEPTH-1:0][WIDTH-1:0] w_regs;

    // A write is effective only out of reset and never to register 0. This
    // same qualifier gates forwarding, so a discarded write is never bypassed.
    logic w_wr_active;
    assign w_wr_active = reg_write && rst_n && (write_reg != '0);

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < C_DEPTH; i++) begin : g_reg
            if (i == 0) begin : g_zero
                assign w_regs[i] = '0;
            end else begin : g_store
                localparam logic [ADDR_W-1:0] C_IDX = ADDR_W'(i);

                logic             w_wr_en;
                logic [WIDTH-1:0] r_q;

                assign w_wr_en = reg_write && (write_reg == C_IDX);

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_q <= '0;
                    end else if (w_wr_en) begin
                        r_q <= write_data;
                    end
                end

                assign w_regs[i] = r_q;
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] w_raddr [C_NPORT];
    logic [WIDTH-1:0]  w_rdata [C_NPORT];

    assign w_raddr[0] = read_reg1;
    assign w_raddr[1] = read_reg2;

    generate
        for (genvar p = 0; p < C_NPORT; p++) begin : g_port
            logic [WIDTH-1:0] w_stored;

            // Register 0 needs no special case here: its array entry is zero.
            assign w_stored = w_regs[w_raddr[p]];

            if (BYPASS != 0) begin : g_bypass
                logic w_hit;

                // write_reg is known non-zero when w_wr_active is set, so an
                // address match also excludes forwarding onto register 0.
                assign w_hit      = w_wr_active && (w_raddr[p] == write_reg);
                assign w_rdata[p] = w_hit ? write_data : w_stored;
            end else begin : g_no_bypass
                assign w_rdata[p] = w_stored;
            end
        end
    endgenerate

    assign read_data1 = w_rdata[0];
    assign read_data2 = w_rdata[1];

endmodule
`default_nettype wire
